// File: rtl/mpf_vtp_port_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpf_vtp_port_mux_pkg
// Purpose  : Shared types and helpers for the VTP multi-port request mux:
//            port index / tag type, per-port head state, statistics counter
//            width and the round-robin pointer advance function.
// Revision : 1.0 - initial release
// ============================================================================
package mpf_vtp_port_mux_pkg;

  // Wide enough to name any of the supported 1..16 client ports.
  localparam int c_PORT_IDX_W = 4;

  // Width of every statistics counter.
  localparam int c_STAT_WIDTH = 32;

  typedef logic [c_PORT_IDX_W-1:0] t_port_idx;

  // RUN   : head may be issued (subject to limits and downstream credit).
  // DRAIN : head is an ordered request waiting for earlier translations.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } t_head_state;

  // (ptr + 1) mod n, written as a compare so no divider is built.
  // Callers always pass ptr < n.
  function automatic t_port_idx rr_next(input t_port_idx ptr, input int unsigned n);
    if ((32'(ptr) + 32'd1) >= n) begin
      return '0;
    end
    return ptr + t_port_idx'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpf_svc_vtp_port_mux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mpf_svc_vtp_port_mux_fifo
// Purpose  : Per-port request FIFO for the VTP port mux. Show-ahead head,
//            registered almost-full flag and free-slot count.
// Revision : 1.0 - initial release
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   enq, enqData : write strobe and data (dropped when full)
//   deq          : pop the head (ignored when empty)
//   headData     : current head entry
//   notEmpty     : at least one entry held
//   almostFull   : registered, set when free slots <= THRESHOLD
//   freeSlots    : DEPTH - occupancy
// ============================================================================
module mpf_svc_vtp_port_mux_fifo #(
  parameter int WIDTH     = 65,
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] enqData,
  input  logic             deq,
  output logic [WIDTH-1:0] headData,
  output logic             notEmpty,
  output logic             almostFull,
  output logic [CNT_W-1:0] freeSlots
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_almostFull;
  logic             w_full;
  logic             w_doEnq;
  logic             w_doDeq;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_doEnq = enq & ~w_full;
  assign w_doDeq = deq & (r_count != '0);

  always_comb begin
    w_countNext = r_count;
    if (w_doEnq && !w_doDeq) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_doEnq && w_doDeq) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_almostFull <= 1'b0;
    end else begin
      if (w_doEnq) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doDeq) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count      <= w_countNext;
      // Evaluated on the next occupancy so the flag is visible the cycle
      // after the enqueue that crosses the threshold.
      r_almostFull <= ((CNT_W'(DEPTH) - w_countNext) <= CNT_W'(THRESHOLD));
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_doEnq) begin
      r_mem[r_wrPtr] <= enqData;
    end
  end

  // Client protocol error: enqueue while full is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_enqWhenFull: assert (!(enq && w_full));
    end
  end

  assign headData   = r_mem[r_rdPtr];
  assign notEmpty   = (r_count != '0);
  assign almostFull = r_almostFull;
  assign freeSlots  = CNT_W'(DEPTH) - r_count;

endmodule
`default_nettype wire

// File: rtl/mpf_svc_vtp_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : mpf_svc_vtp_port_mux
// Purpose  : Multi-port front end of the VTP translation service. Buffers
//            N_PORTS request streams, round-robin arbitrates them into one
//            tagged stream, enforces per-port outstanding limits, holds
//            ordered (fence) requests until the port drains, and routes
//            tagged responses back to their port.
// Revision : 1.0 - initial release
//
// Optional : define MPF_VTP_PORT_MUX_STATS_EN to build the per-port issue
//            and fence-stall counters; otherwise they read as zero.
//
// Ports
//   clk, reset                     : clock, synchronous active-high reset
//   in_reqEn/in_req/in_reqIsOrdered: per-port request enqueue (flattened)
//   in_almostFull                  : per-port registered flow control
//   out_reqEn/out_req/out_reqTag   : registered issued request + source port
//   out_almostFull                 : lookup pipeline back-pressure
//   svc_rspValid/svc_rspTag/svc_rsp: tagged response from lookup pipeline
//   port_rspValid/port_rsp         : registered one-hot response delivery
//   stat_issued/stat_fenceStall    : per-port 32-bit counters (flattened)
// ============================================================================
module mpf_svc_vtp_port_mux
  import mpf_vtp_port_mux_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int REQ_WIDTH       = 64,
  parameter int RSP_WIDTH       = 64,
  parameter int FIFO_DEPTH      = 16,
  parameter int THRESHOLD       = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int TAG_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_PORTS-1:0]                in_reqEn,
  input  logic [N_PORTS*REQ_WIDTH-1:0]      in_req,
  input  logic [N_PORTS-1:0]                in_reqIsOrdered,
  output logic [N_PORTS-1:0]                in_almostFull,
  output logic                              out_reqEn,
  output logic [REQ_WIDTH-1:0]              out_req,
  output logic [TAG_W-1:0]                  out_reqTag,
  input  logic                              out_almostFull,
  input  logic                              svc_rspValid,
  input  logic [TAG_W-1:0]                  svc_rspTag,
  input  logic [RSP_WIDTH-1:0]              svc_rsp,
  output logic [N_PORTS-1:0]                port_rspValid,
  output logic [RSP_WIDTH-1:0]              port_rsp,
  output logic [N_PORTS*c_STAT_WIDTH-1:0]   stat_issued,
  output logic [N_PORTS*c_STAT_WIDTH-1:0]   stat_fenceStall
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [N_PORTS-1:0]           w_notEmpty;
  logic [N_PORTS-1:0]           w_headOrdered;
  logic [N_PORTS-1:0]           w_eligible;
  logic [N_PORTS-1:0]           w_grant;
  logic [N_PORTS-1:0]           w_rspHit;
  logic [N_PORTS*REQ_WIDTH-1:0] w_headReq;
  logic [N_PORTS*CNT_W-1:0]     w_unusedFreeSlots;
  t_port_idx                    r_rrPtr;
  t_port_idx                    w_grantIdx;
  logic [REQ_WIDTH-1:0]         w_grantReq;
  logic                         w_grantValid;
  logic                         w_rspTagValid;
  int                           w_cand;

  assign w_rspTagValid = (32'(svc_rspTag) < N_PORTS);

  // --------------------------------------------------------------------------
  // Per-port FIFO, head state and outstanding counter
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [REQ_WIDTH:0] w_head;
    logic [OUT_W-1:0]   r_outstanding;
    t_head_state        w_headState;

    mpf_svc_vtp_port_mux_fifo #(
      .WIDTH     (REQ_WIDTH + 1),
      .DEPTH     (FIFO_DEPTH),
      .THRESHOLD (THRESHOLD)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .enq        (in_reqEn[p]),
      .enqData    ({in_reqIsOrdered[p], in_req[p*REQ_WIDTH +: REQ_WIDTH]}),
      .deq        (w_grant[p]),
      .headData   (w_head),
      .notEmpty   (w_notEmpty[p]),
      .almostFull (in_almostFull[p]),
      .freeSlots  (w_unusedFreeSlots[p*CNT_W +: CNT_W])
    );

    assign w_headOrdered[p]                   = w_head[REQ_WIDTH];
    assign w_headReq[p*REQ_WIDTH +: REQ_WIDTH] = w_head[REQ_WIDTH-1:0];

    // The head state is a pure function of the head and the counter, so a
    // response that drains the port makes the fence eligible next cycle.
    always_comb begin
      w_headState = RUN;
      if (w_notEmpty[p] && w_headOrdered[p] && (r_outstanding != '0)) begin
        w_headState = DRAIN;
      end
    end

    // RUN with a non-empty FIFO already covers "ordered head needs zero
    // outstanding"; the limit and downstream credit are checked on top.
    assign w_eligible[p] = w_notEmpty[p]
                         && (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                         && (w_headState == RUN)
                         && !out_almostFull;

    assign w_rspHit[p] = svc_rspValid && w_rspTagValid && (32'(svc_rspTag) == p);

    // Issue and response together cancel, even at zero; a lone response at
    // zero (e.g. one arriving after reset) leaves the counter at zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_outstanding <= '0;
      end else if (w_grant[p] && !w_rspHit[p]) begin
        r_outstanding <= r_outstanding + OUT_W'(1);
      end else if (!w_grant[p] && w_rspHit[p] && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - OUT_W'(1);
      end
    end

`ifdef MPF_VTP_PORT_MUX_STATS_EN
    logic [c_STAT_WIDTH-1:0] r_statIssued;
    logic [c_STAT_WIDTH-1:0] r_statStall;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_statIssued <= '0;
        r_statStall  <= '0;
      end else begin
        if (w_grant[p] && (r_statIssued != '1)) begin
          r_statIssued <= r_statIssued + c_STAT_WIDTH'(1);
        end
        if ((w_headState == DRAIN) && (r_statStall != '1)) begin
          r_statStall <= r_statStall + c_STAT_WIDTH'(1);
        end
      end
    end

    assign stat_issued[p*c_STAT_WIDTH +: c_STAT_WIDTH]     = r_statIssued;
    assign stat_fenceStall[p*c_STAT_WIDTH +: c_STAT_WIDTH] = r_statStall;
`endif
  end

`ifndef MPF_VTP_PORT_MUX_STATS_EN
  assign stat_issued     = '0;
  assign stat_fenceStall = '0;
`endif

  // Occupancy is exported by the FIFO but flow control here uses its flag.
  logic w_unused;
  assign w_unused = ^w_unusedFreeSlots;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: scan from r_rrPtr, first eligible port wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_grantReq   = '0;
    w_grant      = '0;
    w_cand       = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_cand = int'(r_rrPtr) + i;
      if (w_cand >= N_PORTS) begin
        w_cand = w_cand - N_PORTS;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (!w_grantValid && (p == w_cand) && w_eligible[p]) begin
          w_grantValid = 1'b1;
          w_grantIdx   = t_port_idx'(p);
          w_grantReq   = w_headReq[p*REQ_WIDTH +: REQ_WIDTH];
          w_grant[p]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr    <= '0;
      out_reqEn  <= 1'b0;
      out_req    <= '0;
      out_reqTag <= '0;
    end else begin
      out_reqEn <= w_grantValid;
      if (w_grantValid) begin
        out_req    <= w_grantReq;
        out_reqTag <= w_grantIdx[TAG_W-1:0];
        r_rrPtr    <= rr_next(w_grantIdx, N_PORTS);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response routing (never back-pressured)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      port_rspValid <= '0;
      port_rsp      <= '0;
    end else begin
      port_rspValid <= w_rspHit;
      if (svc_rspValid) begin
        port_rsp <= svc_rsp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && svc_rspValid) begin
      a_rspTagRange: assert (w_rspTagValid);
    end
  end

endmodule
`default_nettype wire

// File: doc/mpf_svc_vtp_port_mux.md
Name: mpf_svc_vtp_port_mux

Overview:
Multi-channel front end for the VTP translation service. It accepts N_PORTS independent AFU translation request streams, buffers each in a per-port FIFO, and round-robin arbitrates them into one tagged request stream toward the L1/L2 lookup pipeline. Tagged responses are routed back to the originating port. Per-port outstanding limits are enforced, and ordered requests (fences) are held until that port's in-flight translations drain.

Parameters:
N_PORTS, 4, number of client translation ports (1..16)
REQ_WIDTH, 64, opaque request payload bits (VA page index plus metadata)
RSP_WIDTH, 64, opaque response payload bits
FIFO_DEPTH, 16, per-port input FIFO entries (power of 2, >= 4)
THRESHOLD, 4, almost-full asserts when free FIFO slots <= THRESHOLD
MAX_OUTSTANDING, 8, per-port limit on issued-but-unanswered requests

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_reqEn  in  N_PORTS  per-port request enqueue
in_req  in  N_PORTS x REQ_WIDTH  per-port request payload
in_reqIsOrdered  in  N_PORTS  request is a fence/ordered translation
in_almostFull  out  N_PORTS  per-port flow control to client
out_reqEn  out  1  request issued to lookup pipeline
out_req  out  REQ_WIDTH  issued payload
out_reqTag  out  $clog2(N_PORTS) (min 1)  source port of issued request
out_almostFull  in  1  lookup pipeline cannot accept
svc_rspValid  in  1  lookup response valid
svc_rspTag  in  $clog2(N_PORTS) (min 1)  port the response belongs to
svc_rsp  in  RSP_WIDTH  response payload
port_rspValid  out  N_PORTS  one-hot response strobe
port_rsp  out  RSP_WIDTH  response payload, shared by all ports
stat_issued  out  N_PORTS x 32  per-port issued count (optional feature)
stat_fenceStall  out  N_PORTS x 32  per-port fence-stall cycles (optional feature)

Behaviour:
- Reset: all FIFOs empty, outstanding counters 0, RR pointer 0, out_reqEn=0, port_rspValid=0, in_almostFull=0, stats 0. Reset mid-operation discards buffered and in-flight state; responses arriving afterwards are still routed, and the counter does not underflow.
- Enqueue: in_reqEn writes the port FIFO in the same cycle. Enqueue while full is a client protocol error; the request is dropped and a simulation assertion fires.
- in_almostFull is registered, from free slots <= THRESHOLD. Clients may issue up to THRESHOLD further requests after it rises.
- Eligibility of port p requires all of the following:
  - FIFO non-empty.
  - outstanding[p] < MAX_OUTSTANDING.
  - If the head is ordered, outstanding[p] == 0.
  - out_almostFull == 0.
- Per-port head FSM:
  - RUN: head unordered, or outstanding==0.
  - DRAIN: head ordered and outstanding>0; no issue from this port.
  - DRAIN -> RUN when outstanding reaches 0.
  - Other ports are unaffected by a port in DRAIN.
- Arbitration: one grant per cycle, round-robin starting at RR pointer. After a grant, the pointer moves to the granted port + 1, modulo N_PORTS, wrapping at N_PORTS-1 -> 0.
- Issue: the granted head is dequeued. out_reqEn/out_req/out_reqTag are registered, so latency is 1 cycle from grant. Min enqueue-to-issue latency is 2 cycles (enqueue, then grant/dequeue, then registered output).
- Outstanding counter, $clog2(MAX_OUTSTANDING+1) bits:
  - +1 on issue.
  - -1 on a response with matching tag.
  - Both in the same cycle: unchanged.
  - Response at 0: stays 0.
- Responses are not backpressured. port_rspValid[svc_rspTag] and port_rsp are registered, latency 1. Tags >= N_PORTS are dropped and raise an assertion.
- Fence ordering: an ordered request issues only after every earlier request from the same port has received its response. Later requests from that port cannot pass it because the FIFO is in order.

Optional Feature:
MPF_VTP_PORT_MUX_STATS_EN
- Defined: stat_issued[p] increments on each issue from p. stat_fenceStall[p] increments each cycle p is in DRAIN. Both are 32-bit, saturating at 0xFFFFFFFF, and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Package mpf_vtp_port_mux_pkg holds:
  - t_port_idx (tag type).
  - t_head_state enum {RUN, DRAIN}.
  - Stat counter width constant.
  - Function rr_next(ptr, n) -> (ptr+1) mod n.
- Sub-module mpf_svc_vtp_port_mux_fifo: per-port FIFO providing head data/isOrdered, notEmpty, registered almostFull, free-slot count, and enqueue-when-full assertion. Instantiated N_PORTS times via generate.

Test Plan:
- Single port: 3 requests on port 0 at cycles 0,1,2 -> out_reqEn with tag 0 at cycles 2,3,4, in order. Responses with tag 0 -> port_rspValid=4'b0001 one cycle later.
- All 4 ports enqueue continuously, out_almostFull=0 -> grant tags 0,1,2,3,0,1..., each port issued once per 4 cycles.
- Port 1: 2 unordered requests then 1 ordered, no responses -> 2 issue, port 1 enters DRAIN and stat_fenceStall[1] counts. Second response -> ordered request issues 2 cycles later.
- MAX_OUTSTANDING=8, no responses -> port 2 issues exactly 8 then stops. One response -> exactly 1 more issue. Issue and response in the same cycle -> counter unchanged.
- FIFO_DEPTH=16, THRESHOLD=4, out_almostFull=1 -> in_almostFull[0] rises the cycle after the 12th enqueue, and 16 entries are held without loss.
- Reset asserted with 5 outstanding and 3 buffered -> no output issued post-reset. A late response tagged 0 -> port_rspValid[0] pulses and outstanding stays 0.
